// File: rtl/vga_timing_pkg.sv
// Shared timing definitions for the VGA timing controller.
// Holds the counter width, the default 640x480@60 timing and the one-hot
// phase encoding used by both the horizontal and the vertical sequencer.
package vga_timing_pkg;

    localparam int unsigned CNT_W = 10;

    localparam int unsigned DEF_H_FP   = 16;
    localparam int unsigned DEF_H_SYNC = 96;
    localparam int unsigned DEF_H_BP   = 48;
    localparam int unsigned DEF_H_VID  = 640;
    localparam int unsigned DEF_V_FP   = 10;
    localparam int unsigned DEF_V_SYNC = 2;
    localparam int unsigned DEF_V_BP   = 33;
    localparam int unsigned DEF_V_VID  = 480;

    typedef enum logic [3:0] {
        FRONT_PORCH = 4'b0001,
        SYNC        = 4'b0010,
        BACK_PORCH  = 4'b0100,
        VIDEO       = 4'b1000
    } phase_t;

endpackage

// File: rtl/vga_timing_ctrl_phase_seq.sv
// phase_seq: four-phase counter (front porch -> sync -> back porch -> video).
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_adv          : advance one count this cycle
//   i_clr          : force front porch count 0 (wins over i_adv)
//   o_phase        : current phase (registered)
//   o_count        : count within the phase, 0..len-1 (registered)
//   o_wrap_c       : last count of the video phase (combinational decode)
module phase_seq
    import vga_timing_pkg::*;
#(
    parameter int unsigned FP_LEN   = DEF_H_FP,
    parameter int unsigned SYNC_LEN = DEF_H_SYNC,
    parameter int unsigned BP_LEN   = DEF_H_BP,
    parameter int unsigned VID_LEN  = DEF_H_VID
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_adv,
    input  logic             i_clr,
    output phase_t           o_phase,
    output logic [CNT_W-1:0] o_count,
    output logic             o_wrap_c
);

    phase_t           r_phase;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_last;
    phase_t           w_next_phase;

    // Terminal count and successor for the current phase
    always_comb begin
        w_last       = '0;
        w_next_phase = FRONT_PORCH;
        case (r_phase)
            FRONT_PORCH: begin
                w_last       = CNT_W'(FP_LEN - 1);
                w_next_phase = SYNC;
            end
            SYNC: begin
                w_last       = CNT_W'(SYNC_LEN - 1);
                w_next_phase = BACK_PORCH;
            end
            BACK_PORCH: begin
                w_last       = CNT_W'(BP_LEN - 1);
                w_next_phase = VIDEO;
            end
            VIDEO: begin
                w_last       = CNT_W'(VID_LEN - 1);
                w_next_phase = FRONT_PORCH;
            end
            default: begin
                w_last       = '0;
                w_next_phase = FRONT_PORCH;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_phase <= FRONT_PORCH;
            r_count <= '0;
        end else if (i_clr) begin
            r_phase <= FRONT_PORCH;
            r_count <= '0;
        end else if (i_adv) begin
            if (r_count == w_last) begin
                r_phase <= w_next_phase;
                r_count <= '0;
            end else begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    assign o_phase  = r_phase;
    assign o_count  = r_count;
    assign o_wrap_c = (r_phase == VIDEO) && (r_count == CNT_W'(VID_LEN - 1));

endmodule

// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: VGA sync/active-video timing generator.
// Ports:
//   pixelClk, rst : pixel clock, asynchronous active-low reset
//   enable        : run request, honoured only when idle or at the frame boundary
//   running       : timing sequence active
//   hsync, vsync  : active-low sync pulses
//   dataValid     : active-video pixel
//   pixelX/Y      : active column/row, 0 outside active video
//   frameStart    : pulse on pixel (0,0)
//   lineEnd       : pulse on the last active pixel of each active line
// All outputs are decodes of registered state; they change with the state,
// so reset forces them idle without waiting for a clock edge.
module vga_timing_ctrl
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_FP   = DEF_H_FP,
    parameter int unsigned H_SYNC = DEF_H_SYNC,
    parameter int unsigned H_BP   = DEF_H_BP,
    parameter int unsigned H_VID  = DEF_H_VID,
    parameter int unsigned V_FP   = DEF_V_FP,
    parameter int unsigned V_SYNC = DEF_V_SYNC,
    parameter int unsigned V_BP   = DEF_V_BP,
    parameter int unsigned V_VID  = DEF_V_VID
) (
    input  logic             pixelClk,
    input  logic             rst,
    input  logic             enable,
    output logic             running,
    output logic             hsync,
    output logic             vsync,
    output logic             dataValid,
    output logic [CNT_W-1:0] pixelX,
    output logic [CNT_W-1:0] pixelY,
    output logic             frameStart,
    output logic             lineEnd
);

    logic             r_running;
    phase_t           w_h_phase;
    phase_t           w_v_phase;
    logic [CNT_W-1:0] w_h_count;
    logic [CNT_W-1:0] w_v_count;
    logic             w_h_wrap;
    logic             w_v_wrap;
    logic             w_v_adv;
    logic             w_clr;
    logic             w_dv;
    logic             w_frame_end;

    // Idle holds both sequencers at front porch 0; a line ends on the last video pixel
    assign w_clr       = ~r_running;
    assign w_v_adv     = r_running & w_h_wrap;
    assign w_frame_end = w_h_wrap & w_v_wrap;

    phase_seq #(
        .FP_LEN  (H_FP),
        .SYNC_LEN(H_SYNC),
        .BP_LEN  (H_BP),
        .VID_LEN (H_VID)
    ) u_h_seq (
        .i_clk   (pixelClk),
        .i_rst_n (rst),
        .i_adv   (r_running),
        .i_clr   (w_clr),
        .o_phase (w_h_phase),
        .o_count (w_h_count),
        .o_wrap_c(w_h_wrap)
    );

    phase_seq #(
        .FP_LEN  (V_FP),
        .SYNC_LEN(V_SYNC),
        .BP_LEN  (V_BP),
        .VID_LEN (V_VID)
    ) u_v_seq (
        .i_clk   (pixelClk),
        .i_rst_n (rst),
        .i_adv   (w_v_adv),
        .i_clr   (w_clr),
        .o_phase (w_v_phase),
        .o_count (w_v_count),
        .o_wrap_c(w_v_wrap)
    );

    // Run flag: enable is only looked at while idle or on the frame's last pixel,
    // where both sequencers naturally wrap back to front porch 0
    always_ff @(posedge pixelClk or negedge rst) begin
        if (!rst) begin
            r_running <= 1'b0;
        end else if (!r_running || w_frame_end) begin
            r_running <= enable;
        end
    end

    assign w_dv       = r_running & (w_h_phase == VIDEO) & (w_v_phase == VIDEO);
    assign running    = r_running;
    assign hsync      = ~(r_running & (w_h_phase == SYNC));
    assign vsync      = ~(r_running & (w_v_phase == SYNC));
    assign dataValid  = w_dv;
    assign pixelX     = w_dv ? w_h_count : '0;
    assign pixelY     = w_dv ? w_v_count : '0;
    assign lineEnd    = w_dv & w_h_wrap;
    assign frameStart = w_dv & (w_h_count == '0) & (w_v_count == '0);

endmodule
